// File: rtl/sram_like_arbiter_pkg.sv
// Shared sram-like bus encodings and arbitration mode constants.
package sram_like_arbiter_pkg;

  localparam logic [2:0] SRAM_SIZE_BYTE = 3'd0;
  localparam logic [2:0] SRAM_SIZE_HALF = 3'd1;
  localparam logic [2:0] SRAM_SIZE_WORD = 3'd2;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  function automatic int id_width(input int n_ch);
    return (n_ch > 2) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of channel ids for accepted-but-not-returned requests.
module arb_id_fifo #(
  parameter  int ID_W  = 1,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [ID_W-1:0]  din,
  output logic [ID_W-1:0]  dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel sram-like master merger onto one slave port, with in-order
// return routing through an id FIFO.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter  int N_CH        = 2,
  parameter  int OUTSTANDING = 4,
  parameter  int RR_MODE     = ARB_MODE_RR,
  localparam int ID_W        = id_width(N_CH),
  localparam int CNT_W       = $clog2(OUTSTANDING) + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N_CH-1:0]      m_req,
  input  logic [N_CH-1:0]      m_wr,
  input  logic [3*N_CH-1:0]    m_size,
  input  logic [32*N_CH-1:0]   m_addr,
  input  logic [4*N_CH-1:0]    m_wstrb,
  input  logic [32*N_CH-1:0]   m_wdata,
  output logic [N_CH-1:0]      m_addrok,
  output logic [N_CH-1:0]      m_dataok,
  output logic [31:0]          m_rdata,
  output logic                 s_req,
  output logic                 s_wr,
  output logic [2:0]           s_size,
  output logic [31:0]          s_addr,
  output logic [3:0]           s_wstrb,
  output logic [31:0]          s_wdata,
  input  logic                 s_addrok,
  input  logic                 s_dataok,
  input  logic [31:0]          s_rdata,
  output logic [CNT_W-1:0]     outstanding_cnt,
  output logic                 proto_err
);

  logic            lock;
  logic [ID_W-1:0] locked_id;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] head_id;
  logic [ID_W-1:0] off;
  logic [ID_W:0]   grant_sum;
  logic [N_CH-1:0] req_rot;
  logic            any_cand;
  logic            full;
  logic            empty;
  logic            accept;
  logic            pop;

  function automatic logic [ID_W-1:0] first_set(input logic [N_CH-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  // Search requests rotated so rr_ptr sits at bit 0; in fixed mode rr_ptr
  // never leaves 0, which reduces this to lowest-index priority.
  always_comb begin
    req_rot   = N_CH'({m_req, m_req} >> rr_ptr);
    off       = first_set(req_rot);
    grant_sum = {1'b0, rr_ptr} + {1'b0, off};
    if (grant_sum >= (ID_W + 1)'(N_CH)) grant_sum = grant_sum - (ID_W + 1)'(N_CH);
    grant    = lock ? locked_id : grant_sum[ID_W-1:0];
    any_cand = lock | (|m_req);
  end

  assign s_req    = any_cand & ~full;
  assign accept   = s_req & s_addrok;
  assign pop      = s_dataok & ~empty;
  assign next_ptr = (grant == ID_W'(N_CH - 1)) ? '0 : grant + 1'b1;

  assign s_wr    = s_req & m_wr[grant];
  assign s_size  = s_req ? m_size[grant*3 +: 3]   : '0;
  assign s_addr  = s_req ? m_addr[grant*32 +: 32] : '0;
  assign s_wstrb = s_req ? m_wstrb[grant*4 +: 4]  : '0;
  assign s_wdata = s_req ? m_wdata[grant*32 +: 32] : '0;

  assign m_addrok = accept ? (N_CH'(1) << grant)   : '0;
  assign m_dataok = pop    ? (N_CH'(1) << head_id) : '0;
  assign m_rdata  = s_dataok ? s_rdata : '0;

  arb_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .din    (grant),
    .dout   (head_id),
    .count  (outstanding_cnt),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock      <= 1'b0;
      rr_ptr    <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept)     lock <= 1'b0;
      else if (s_req) lock <= 1'b1;
      if (accept && (RR_MODE == ARB_MODE_RR)) rr_ptr <= next_ptr;
      if (s_dataok && empty) proto_err <= 1'b1;
    end
  end

  // A stalled request keeps its channel until the slave takes it.
  always_ff @(posedge clk) begin
    if (s_req && !s_addrok) locked_id <= grant;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed scoreboard bench: fixed-priority 2-channel and round-robin 3-channel arbiters.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  // Instance A: N_CH=2, fixed priority
  logic [1:0]  a_req, a_wr, a_addrok_m, a_dataok_m;
  logic [5:0]  a_size;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_wstrb;
  logic [31:0] a_rdata_m, a_saddr, a_swdata, a_srdata;
  logic        a_sreq, a_swr, a_saddrok, a_sdataok, a_perr;
  logic [2:0]  a_ssize, a_cnt;
  logic [3:0]  a_swstrb;

  // Instance B: N_CH=3, round robin
  logic [2:0]  b_req, b_wr, b_addrok_m, b_dataok_m;
  logic [8:0]  b_size;
  logic [95:0] b_addr, b_wdata;
  logic [11:0] b_wstrb;
  logic [31:0] b_rdata_m, b_saddr, b_swdata, b_srdata;
  logic        b_sreq, b_swr, b_saddrok, b_sdataok, b_perr;
  logic [2:0]  b_ssize, b_cnt;
  logic [3:0]  b_swstrb;

  int a_q[$];
  int b_q[$];
  int n_cmp = 0;
  int n_err = 0;

  sram_like_arbiter #(.N_CH(2), .OUTSTANDING(4), .RR_MODE(ARB_MODE_FIXED)) dut_a (
    .clk(clk), .resetn(resetn),
    .m_req(a_req), .m_wr(a_wr), .m_size(a_size), .m_addr(a_addr),
    .m_wstrb(a_wstrb), .m_wdata(a_wdata),
    .m_addrok(a_addrok_m), .m_dataok(a_dataok_m), .m_rdata(a_rdata_m),
    .s_req(a_sreq), .s_wr(a_swr), .s_size(a_ssize), .s_addr(a_saddr),
    .s_wstrb(a_swstrb), .s_wdata(a_swdata),
    .s_addrok(a_saddrok), .s_dataok(a_sdataok), .s_rdata(a_srdata),
    .outstanding_cnt(a_cnt), .proto_err(a_perr)
  );

  sram_like_arbiter #(.N_CH(3), .OUTSTANDING(4), .RR_MODE(ARB_MODE_RR)) dut_b (
    .clk(clk), .resetn(resetn),
    .m_req(b_req), .m_wr(b_wr), .m_size(b_size), .m_addr(b_addr),
    .m_wstrb(b_wstrb), .m_wdata(b_wdata),
    .m_addrok(b_addrok_m), .m_dataok(b_dataok_m), .m_rdata(b_rdata_m),
    .s_req(b_sreq), .s_wr(b_swr), .s_size(b_ssize), .s_addr(b_saddr),
    .s_wstrb(b_swstrb), .s_wdata(b_swdata),
    .s_addrok(b_saddrok), .s_dataok(b_sdataok), .s_rdata(b_srdata),
    .outstanding_cnt(b_cnt), .proto_err(b_perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of instance A; exp_g is the channel the bench expects accepted (-1: none).
  task automatic a_cycle(input logic [1:0] req, input logic addrok, input logic dataok,
                         input logic [31:0] rdata, input int exp_g);
    int c;
    a_req = req; a_saddrok = addrok; a_sdataok = dataok; a_srdata = rdata;
    @(negedge clk);
    if (exp_g >= 0) begin
      chk("a_addrok", 32'(a_addrok_m), 32'(1) << exp_g);
      chk("a_saddr", a_saddr, (exp_g == 1) ? 32'h1000 : 32'h100);
      chk("a_swdata", a_swdata, (exp_g == 1) ? 32'h2222_2222 : 32'h1111_1111);
      chk("a_swr", 32'(a_swr), (exp_g == 1) ? 32'd1 : 32'd0);
    end else begin
      chk("a_addrok_none", 32'(a_addrok_m), 32'd0);
    end
    if (dataok) begin
      if (a_q.size() > 0) begin
        c = a_q.pop_front();
        chk("a_dataok", 32'(a_dataok_m), 32'(1) << c);
      end else begin
        chk("a_dataok_empty", 32'(a_dataok_m), 32'd0);
      end
      chk("a_rdata", a_rdata_m, rdata);
    end else begin
      chk("a_dataok_idle", 32'(a_dataok_m), 32'd0);
    end
    if (exp_g >= 0) a_q.push_back(exp_g);
    @(posedge clk); #1;
  endtask

  initial begin
    int c;
    resetn = 1'b0;
    a_req = '0; a_saddrok = 1'b0; a_sdataok = 1'b0; a_srdata = '0;
    a_wr = 2'b10; a_size = {SRAM_SIZE_HALF, SRAM_SIZE_WORD};
    a_addr = {32'h1000, 32'h100}; a_wstrb = {4'h3, 4'hf};
    a_wdata = {32'h2222_2222, 32'h1111_1111};
    b_req = '0; b_saddrok = 1'b0; b_sdataok = 1'b0; b_srdata = '0;
    b_wr = 3'b000; b_size = {SRAM_SIZE_BYTE, SRAM_SIZE_HALF, SRAM_SIZE_WORD};
    b_addr = {32'h2200, 32'h2100, 32'h2000}; b_wstrb = 12'hfff;
    b_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    #1;

    // Reset state
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_perr", 32'(a_perr), 32'd0);
    chk("rst_sreq", 32'(a_sreq), 32'd0);
    chk("rst_saddr", a_saddr, 32'd0);
    chk("rst_swdata", a_swdata, 32'd0);
    chk("rst_b_sreq", 32'(b_sreq), 32'd0);

    // Fixed priority: ch0 wins while held, then ch1
    a_cycle(2'b11, 1'b1, 1'b0, 32'h0, 0);
    a_cycle(2'b11, 1'b1, 1'b0, 32'h0, 0);
    a_cycle(2'b10, 1'b1, 1'b0, 32'h0, 1);
    chk("fp_cnt", 32'(a_cnt), 32'd3);
    for (int i = 0; i < 3; i++) a_cycle(2'b00, 1'b0, 1'b1, 32'hC000 + i, -1);
    chk("fp_cnt_drained", 32'(a_cnt), 32'd0);

    // Lock: stalled ch1 keeps the grant even when ch0 arrives
    a_cycle(2'b10, 1'b0, 1'b0, 32'h0, -1);
    chk("lk_sreq", 32'(a_sreq), 32'd1);
    for (int i = 0; i < 3; i++) begin
      a_cycle(2'b11, 1'b0, 1'b0, 32'h0, -1);
      chk("lk_saddr", a_saddr, 32'h1000);
    end
    a_cycle(2'b11, 1'b1, 1'b0, 32'h0, 1);
    a_cycle(2'b01, 1'b1, 1'b0, 32'h0, 0);
    for (int i = 0; i < 2; i++) a_cycle(2'b00, 1'b0, 1'b1, 32'hD000 + i, -1);

    // Full: no accept even with a same-cycle return
    for (int i = 0; i < 4; i++) a_cycle(2'b01, 1'b1, 1'b0, 32'h0, 0);
    chk("full_cnt", 32'(a_cnt), 32'd4);
    chk("full_sreq", 32'(a_sreq), 32'd0);
    chk("full_saddr", a_saddr, 32'd0);
    a_cycle(2'b01, 1'b1, 1'b1, 32'hF0, -1);
    chk("full_cnt_pop", 32'(a_cnt), 32'd3);
    chk("full_sreq_resume", 32'(a_sreq), 32'd1);
    a_cycle(2'b01, 1'b1, 1'b0, 32'h0, 0);
    chk("full_cnt_refill", 32'(a_cnt), 32'd4);
    for (int i = 0; i < 4; i++) a_cycle(2'b00, 1'b0, 1'b1, 32'hF1 + i, -1);

    // Simultaneous push/pop at count 2 across pointer wrap
    a_cycle(2'b01, 1'b1, 1'b0, 32'h0, 0);
    a_cycle(2'b10, 1'b1, 1'b0, 32'h0, 1);
    for (int i = 0; i < 8; i++) begin
      c = i % 2;
      a_cycle((c == 1) ? 2'b10 : 2'b01, 1'b1, 1'b1, 32'hA000 + i, c);
      chk("pp_cnt", 32'(a_cnt), 32'd2);
    end
    for (int i = 0; i < 2; i++) a_cycle(2'b00, 1'b0, 1'b1, 32'hA100 + i, -1);
    chk("pp_cnt_drained", 32'(a_cnt), 32'd0);

    // Return with empty FIFO: sticky proto_err, cleared by reset with FIFO
    chk("pe_before", 32'(a_perr), 32'd0);
    a_cycle(2'b00, 1'b0, 1'b1, 32'hDEAD, -1);
    chk("pe_set", 32'(a_perr), 32'd1);
    a_cycle(2'b00, 1'b0, 1'b0, 32'h0, -1);
    a_cycle(2'b01, 1'b1, 1'b0, 32'h0, 0);
    chk("pe_sticky", 32'(a_perr), 32'd1);
    chk("pe_cnt", 32'(a_cnt), 32'd1);
    a_req = '0; a_saddrok = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    a_q.delete();
    #1;
    chk("pe_cleared", 32'(a_perr), 32'd0);
    chk("pe_cnt_cleared", 32'(a_cnt), 32'd0);

    // Round robin, 3 channels all requesting: grants 0,1,2,0,1,2
    b_req = 3'b111; b_saddrok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_sdataok = (i > 0);
      b_srdata = 32'hB0 + i;
      @(negedge clk);
      chk("rr_addrok", 32'(b_addrok_m), 32'(1) << (i % 3));
      chk("rr_saddr", b_saddr, 32'h2000 + (i % 3) * 32'h100);
      if (i > 0) begin
        c = b_q.pop_front();
        chk("rr_dataok", 32'(b_dataok_m), 32'(1) << c);
        chk("rr_rdata", b_rdata_m, 32'hB0 + i);
      end
      b_q.push_back(i % 3);
      @(posedge clk); #1;
    end
    b_req = '0; b_saddrok = 1'b0; b_sdataok = 1'b1; b_srdata = 32'hBF;
    @(negedge clk);
    c = b_q.pop_front();
    chk("rr_dataok_last", 32'(b_dataok_m), 32'(1) << c);
    @(posedge clk); #1;
    b_sdataok = 1'b0;
    #1;
    chk("rr_cnt", 32'(b_cnt), 32'd0);
    chk("rr_perr", 32'(b_perr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
